// File: rtl/mouse_pkg.sv
// ============================================================================
//  Module      : mouse_pkg
//  Description : Shared types, constants and helpers for the PS/2 mouse
//                cursor/button tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mouse_pkg;

    localparam int PS2_DELTA_W = 9;
    localparam int MAX_BTN     = 8;
    localparam int IDX_W       = $clog2(MAX_BTN);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             press;
    } evt_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_e;

    // Saturate v into the range 0..hi.
    function automatic int clamp(input int v, input int hi);
        if (v < 0)
            return 0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Double a delta whose magnitude reaches thresh; sign is preserved.
    function automatic int accel(input int d, input int thresh, input bit en);
        if (en && ((d >= thresh) || (d <= -thresh)))
            return 2 * d;
        else
            return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mouse_pos_tracker_if.sv
// ============================================================================
//  Module      : mouse_pos_tracker_if
//  Description : Packet, host-control and status bundle of the tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mouse_pos_tracker_if
    import mouse_pkg::*;
#(
    parameter int NBTN = 3,
    parameter int XW   = 10,
    parameter int YW   = 9
);
    logic                   pkt_valid_i;
    logic [PS2_DELTA_W-1:0] dx_i;
    logic [PS2_DELTA_W-1:0] dy_i;
    logic [NBTN-1:0]        btn_i;
    logic                   set_i;
    logic [XW-1:0]          set_x_i;
    logic [YW-1:0]          set_y_i;
    logic [NBTN-1:0]        ack_i;
    logic                   evt_pop_i;
    logic                   ovf_clr_i;

    logic [XW-1:0]          x_pos_o;
    logic [YW-1:0]          y_pos_o;
    logic [NBTN-1:0]        btn_level_o;
    logic [NBTN-1:0]        btn_sticky_o;
    logic                   evt_valid_o;
    logic [IDX_W-1:0]       evt_idx_o;
    logic                   evt_press_o;
    logic                   evt_ovf_o;

    modport master (
        output pkt_valid_i, dx_i, dy_i, btn_i, set_i, set_x_i, set_y_i,
               ack_i, evt_pop_i, ovf_clr_i,
        input  x_pos_o, y_pos_o, btn_level_o, btn_sticky_o, evt_valid_o,
               evt_idx_o, evt_press_o, evt_ovf_o
    );

    modport slave (
        input  pkt_valid_i, dx_i, dy_i, btn_i, set_i, set_x_i, set_y_i,
               ack_i, evt_pop_i, ovf_clr_i,
        output x_pos_o, y_pos_o, btn_level_o, btn_sticky_o, evt_valid_o,
               evt_idx_o, evt_press_o, evt_ovf_o
    );

endinterface

`default_nettype wire

// File: rtl/mouse_evt_fifo.sv
// ============================================================================
//  Module      : mouse_evt_fifo
//  Description : Synchronous FIFO of button events; a pop on empty is ignored,
//                a push on full is accepted only when a pop frees a slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_evt_fifo
    import mouse_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic clk_i,
    input  wire logic rstn_i,
    input  wire logic push_i,
    input  evt_t      data_i,
    input  wire logic pop_i,
    output evt_t      data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    evt_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/mouse_pos_tracker.sv
// ============================================================================
//  Module      : mouse_pos_tracker
//  Description : Clamped cursor position, button levels/sticky flags and a
//                press/release event FIFO driven by decoded PS/2 packets.
//                Optional macro MOUSE_POS_ACCEL_EN doubles large deltas.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int NBTN         = 3,
    parameter int INVERT_Y     = 1,
    parameter int EVT_DEPTH    = 8,
    parameter int ACCEL_THRESH = 16
) (
    input  wire logic      clk_i,
    input  wire logic      rstn_i,
    mouse_pos_tracker_if.slave bus
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
`ifdef MOUSE_POS_ACCEL_EN
    localparam bit ACCEL_EN = 1'b1;
`else
    localparam bit ACCEL_EN = 1'b0;
`endif

    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [NBTN-1:0] level_q, level_d;
    logic [NBTN-1:0] sticky_q, sticky_d;
    logic [NBTN-1:0] pending_q, pending_d;
    logic            ovf_q, ovf_d;
    emit_state_e     state_q, state_d;

    int              dx_eff;
    int              dy_eff;
    logic [NBTN-1:0] emit_clr;
    logic [NBTN-1:0] toggles;
    logic            push;
    evt_t            push_evt;
    evt_t            head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    // Position: a warp takes priority and discards same-cycle motion.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        dx_eff = accel(int'($signed(bus.dx_i)), ACCEL_THRESH, ACCEL_EN);
        dy_eff = accel(int'($signed(bus.dy_i)), ACCEL_THRESH, ACCEL_EN);
        if (INVERT_Y != 0)
            dy_eff = -dy_eff;
        if (bus.set_i) begin
            x_d = XW'(clamp(int'(bus.set_x_i), WIDTH - 1));
            y_d = YW'(clamp(int'(bus.set_y_i), HEIGHT - 1));
        end else if (bus.pkt_valid_i) begin
            x_d = XW'(clamp(int'(x_q) + dx_eff, WIDTH - 1));
            y_d = YW'(clamp(int'(y_q) + dy_eff, HEIGHT - 1));
        end
    end

    // Emitter picks the lowest pending bit; new toggles are XORed in after it clears.
    always_comb begin
        emit_clr = '0;
        push     = 1'b0;
        push_evt = '0;
        case (state_q)
            ST_EMIT: begin
                for (int i = NBTN - 1; i >= 0; i--) begin
                    if (pending_q[i]) begin
                        push_evt.idx   = IDX_W'(i);
                        push_evt.press = level_q[i];
                        emit_clr       = NBTN'(1) << i;
                    end
                end
                push = |pending_q;
            end
            default: ;
        endcase
        toggles   = bus.pkt_valid_i ? (bus.btn_i ^ level_q) : '0;
        pending_d = (pending_q & ~emit_clr) ^ toggles;
        state_d   = (pending_d != '0) ? ST_EMIT : ST_IDLE;
        level_d   = bus.pkt_valid_i ? bus.btn_i : level_q;
        sticky_d  = (sticky_q | (bus.pkt_valid_i ? bus.btn_i : '0)) & ~bus.ack_i;
        drop      = push & fifo_full & ~bus.evt_pop_i;
        ovf_d     = (ovf_q & ~bus.ovf_clr_i) | drop;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_q       <= '0;
            y_q       <= '0;
            level_q   <= '0;
            sticky_q  <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            level_q   <= level_d;
            sticky_q  <= sticky_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
        end
    end

    mouse_evt_fifo #(
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .data_i  (push_evt),
        .pop_i   (bus.evt_pop_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.x_pos_o      = x_q;
    assign bus.y_pos_o      = y_q;
    assign bus.btn_level_o  = level_q;
    assign bus.btn_sticky_o = sticky_q;
    assign bus.evt_valid_o  = ~fifo_empty;
    assign bus.evt_idx_o    = fifo_empty ? '0 : head.idx;
    assign bus.evt_press_o  = fifo_empty ? 1'b0 : head.press;
    assign bus.evt_ovf_o    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mouse_pos_tracker.sv
// ============================================================================
//  Module      : tb_mouse_pos_tracker
//  Description : Self-checking bench for mouse_pos_tracker (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mouse_pos_tracker;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int DEPTH = 8;
`ifdef MOUSE_POS_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mouse_pos_tracker_if #(.NBTN(3), .XW(10), .YW(9)) bus ();

    mouse_pos_tracker #(
        .WIDTH(W), .HEIGHT(H), .NBTN(3), .INVERT_Y(1),
        .EVT_DEPTH(DEPTH), .ACCEL_THRESH(16)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus values for the next clock edge
    int i_pkt, i_dx, i_dy, i_btn, i_set, i_sx, i_sy, i_ack, i_pop, i_oclr;

    // Reference state
    int mx, my, mlvl, msticky, mpend;
    bit movf;
    int mq[$];   // each event encoded as idx*2 + press

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int acc(input int d);
        return (ACC && (d >= 16 || d <= -16)) ? 2 * d : d;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mlvl = 0; msticky = 0; mpend = 0; movf = 0;
        mq.delete();
    endtask

    task automatic model_step();
        int ev  = -1;
        int clr = 0;
        bit drop = 0;
        for (int i = 0; i < 3; i++) begin
            if (((mpend >> i) & 1) == 1) begin
                ev  = i * 2 + ((mlvl >> i) & 1);
                clr = 1 << i;
                break;
            end
        end
        if (i_pop != 0 && mq.size() > 0)
            void'(mq.pop_front());
        if (ev >= 0) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else                   drop = 1;
        end
        movf    = (movf && i_oclr == 0) || drop;
        mpend   = ((mpend & ~clr) ^ (i_pkt != 0 ? (i_btn ^ mlvl) : 0)) & 7;
        msticky = (msticky | (i_pkt != 0 ? i_btn : 0)) & ~i_ack & 7;
        if (i_pkt != 0) mlvl = i_btn;
        if (i_set != 0) begin
            mx = lim(i_sx, W - 1);
            my = lim(i_sy, H - 1);
        end else if (i_pkt != 0) begin
            mx = lim(mx + acc(i_dx), W - 1);
            my = lim(my - acc(i_dy), H - 1);
        end
    endtask

    task automatic check_all();
        chk("x_pos",      int'(bus.x_pos_o),      mx);
        chk("y_pos",      int'(bus.y_pos_o),      my);
        chk("btn_level",  int'(bus.btn_level_o),  mlvl);
        chk("btn_sticky", int'(bus.btn_sticky_o), msticky);
        chk("evt_valid",  int'(bus.evt_valid_o),  mq.size() > 0 ? 1 : 0);
        chk("evt_idx",    int'(bus.evt_idx_o),    mq.size() > 0 ? (mq[0] >> 1) : 0);
        chk("evt_press",  int'(bus.evt_press_o),  mq.size() > 0 ? (mq[0] & 1) : 0);
        chk("evt_ovf",    int'(bus.evt_ovf_o),    int'(movf));
    endtask

    task automatic idle_inputs();
        i_pkt = 0; i_dx = 0; i_dy = 0; i_btn = mlvl; i_set = 0;
        i_sx = 0; i_sy = 0; i_ack = 0; i_pop = 0; i_oclr = 0;
    endtask

    task automatic step();
        bus.pkt_valid_i = 1'(i_pkt);
        bus.dx_i        = 9'(i_dx);
        bus.dy_i        = 9'(i_dy);
        bus.btn_i       = 3'(i_btn);
        bus.set_i       = 1'(i_set);
        bus.set_x_i     = 10'(i_sx);
        bus.set_y_i     = 9'(i_sy);
        bus.ack_i       = 3'(i_ack);
        bus.evt_pop_i   = 1'(i_pop);
        bus.ovf_clr_i   = 1'(i_oclr);
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        idle_inputs();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rstn = 1'b1;
    endtask

    typedef struct {
        int pkt; int dx; int dy; int btn;
        int set; int sx; int sy;
        int ex;  int ey;
    } vec_t;

    vec_t tbl[11];

    initial begin
        model_reset();
        idle_inputs();
        // {pkt, dx, dy, btn, set, sx, sy, expected x, expected y}
        tbl[0]  = '{0,    0,    0, 0, 1,  100, 100, 100, 100};
        tbl[1]  = '{1,   10,    5, 0, 0,    0,   0, 110,  95};
        tbl[2]  = '{0,    0,    0, 0, 1,    5,   5,   5,   5};
        tbl[3]  = '{1,  -20, -256, 0, 0,    0,   0,   0, ACC ? 479 : 261};
        tbl[4]  = '{0,    0,    0, 0, 1,  635, 470, 635, 470};
        tbl[5]  = '{1,  100, -100, 0, 0,    0,   0, 639, 479};
        tbl[6]  = '{1,   30,    0, 5, 1,   50,  60,  50,  60};
        tbl[7]  = '{0,    0,    0, 5, 1,  100,   0, 100,   0};
        tbl[8]  = '{1,   20,    0, 5, 0,    0,   0, ACC ? 140 : 120, 0};
        tbl[9]  = '{1,  -85,    0, 5, 1,  100,   0, 100,   0};
        tbl[10] = '{1,   15,    0, 5, 0,    0,   0, 115,   0};

        do_reset();

        for (int k = 0; k < 11; k++) begin
            idle_inputs();
            i_pkt = tbl[k].pkt; i_dx = tbl[k].dx; i_dy = tbl[k].dy;
            i_btn = tbl[k].btn; i_set = tbl[k].set;
            i_sx  = tbl[k].sx;  i_sy  = tbl[k].sy;
            step();
            chk("tbl_x", int'(bus.x_pos_o), tbl[k].ex);
            chk("tbl_y", int'(bus.y_pos_o), tbl[k].ey);
            if (k == 6) chk("warp_btn_level", int'(bus.btn_level_o), 5);
        end

        // Warp coordinates beyond the screen saturate
        idle_inputs(); i_set = 1; i_sx = 1000; i_sy = 511; step();
        chk("warp_clamp_x", int'(bus.x_pos_o), 639);
        chk("warp_clamp_y", int'(bus.y_pos_o), 479);

        // Press of buttons 0 and 2 in a single packet
        do_reset();
        idle_inputs(); i_pkt = 1; i_btn = 5; step();
        chk("press_sticky", int'(bus.btn_sticky_o), 5);
        chk("press_valid0", int'(bus.evt_valid_o), 0);
        idle_inputs(); step();
        chk("ev0_valid", int'(bus.evt_valid_o), 1);
        chk("ev0_idx",   int'(bus.evt_idx_o),   0);
        chk("ev0_press", int'(bus.evt_press_o), 1);
        idle_inputs(); i_pop = 1; step();
        chk("ev1_idx",   int'(bus.evt_idx_o),   2);
        chk("ev1_press", int'(bus.evt_press_o), 1);
        idle_inputs(); i_pop = 1; i_ack = 1; step();
        chk("drained",   int'(bus.evt_valid_o),  0);
        chk("ack_sticky", int'(bus.btn_sticky_o), 4);

        // Nine events into an eight-deep FIFO
        do_reset();
        for (int p = 0; p < 3; p++) begin
            idle_inputs(); i_pkt = 1; i_btn = (p == 1) ? 0 : 7; step();
            repeat (3) begin idle_inputs(); step(); end
        end
        idle_inputs(); step();
        chk("ovf_set",   int'(bus.evt_ovf_o),   1);
        chk("ovf_head",  int'(bus.evt_idx_o),   0);
        chk("ovf_press", int'(bus.evt_press_o), 1);
        idle_inputs(); i_oclr = 1; step();
        chk("ovf_clr", int'(bus.evt_ovf_o), 0);

        // Reset in the middle of emission leaves no events behind
        do_reset();
        idle_inputs(); i_pkt = 1; i_btn = 7; step();
        idle_inputs(); step();
        do_reset();
        repeat (4) begin idle_inputs(); step(); end
        chk("rst_mid_valid",   int'(bus.evt_valid_o), 0);
        chk("rst_mid_pending", int'(bus.btn_level_o), 0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            i_pkt  = ($urandom_range(0, 9) < 3) ? 1 : 0;
            i_dx   = int'($urandom_range(0, 511)) - 256;
            i_dy   = int'($urandom_range(0, 511)) - 256;
            i_btn  = int'($urandom_range(0, 7));
            i_set  = ($urandom_range(0, 19) == 0) ? 1 : 0;
            i_sx   = int'($urandom_range(0, 1023));
            i_sy   = int'($urandom_range(0, 511));
            i_ack  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 0;
            i_pop  = ($urandom_range(0, 9) < 3) ? 1 : 0;
            i_oclr = ($urandom_range(0, 19) == 0) ? 1 : 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mouse_pos_tracker.md
Name: mouse_pos_tracker

Overview:
Parametrised cursor/button tracker fed by the decoded PS/2 mouse packet stream (9-bit signed deltas, button levels, one-cycle packet strobe). Maintains a clamped on-screen cursor position with optional Y inversion and host warp. Generates sticky per-button flags and a FIFO of button press/release events for the peripheral register interface. Sits between the PS/2 mouse decoder and the APB-side register block.

Parameters:
WIDTH, 640, screen width; x range 0..WIDTH-1
HEIGHT, 480, screen height; y range 0..HEIGHT-1
NBTN, 3, number of buttons tracked (1..8)
INVERT_Y, 1, 1 = positive PS/2 dy moves cursor toward y=0 (screen up)
EVT_DEPTH, 8, event FIFO depth (power of 2, >=2)
ACCEL_THRESH, 16, magnitude threshold for acceleration (used only with macro)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
pkt_valid_i  in  1  one-cycle strobe: new packet on dx_i/dy_i/btn_i
dx_i  in  9  signed dx, two's complement
dy_i  in  9  signed dy, two's complement
btn_i  in  NBTN  button levels from packet
set_i  in  1  host warp strobe
set_x_i  in  XW=$clog2(WIDTH)  warp x
set_y_i  in  YW=$clog2(HEIGHT)  warp y
ack_i  in  NBTN  clears matching sticky bits
evt_pop_i  in  1  pop FIFO head
ovf_clr_i  in  1  clears overflow flag
x_pos_o  out  XW  cursor x
y_pos_o  out  YW  cursor y
btn_level_o  out  NBTN  registered button levels
btn_sticky_o  out  NBTN  sticky pressed flags
evt_valid_o  out  1  FIFO non-empty
evt_idx_o  out  3  button index of head event
evt_press_o  out  1  1 = press, 0 = release
evt_ovf_o  out  1  sticky: event dropped on full FIFO

Behaviour:
- Reset: all outputs 0; position (0,0); FIFO empty; pending mask 0.
- Position: on pkt_valid_i, nx = x + sext(dx), ny = y + (INVERT_Y ? -sext(dy) : sext(dy)), computed signed at XW+2/YW+2 bits; clamp to [0,WIDTH-1]/[0,HEIGHT-1]. Registered: visible cycle after strobe. dx = -256 is legal (magnitude 256).
- Warp: set_i loads clamped set_x_i/set_y_i next cycle; set_i wins over same-cycle pkt_valid_i (motion discarded, buttons still processed).
- Buttons: on pkt_valid_i, btn_level <= btn_i; pending <= pending ^ (btn_i ^ btn_level). Bit toggled twice before emission cancels.
- Sticky: sticky <= (sticky | (pkt_valid_i ? btn_i : 0)) & ~ack_i; ack wins over same-cycle set.
- Emitter FSM: IDLE (pending==0) / EMIT. In EMIT, each cycle takes lowest set pending bit i, pushes {i, btn_level[i]}, clears bit i; returns to IDLE when pending becomes 0. Packet bits merge into pending in the same cycle as emission (clear-then-XOR order for same bit: XOR applied after clear).
- FIFO: push on full drops event, sets evt_ovf_o (sticky until ovf_clr_i; set wins over clear same cycle). Simultaneous push+pop on full: pop then push, no drop. Pop on empty ignored. evt_* outputs are the head, valid next cycle after push into empty FIFO.
- Reset mid-emission: pending and FIFO cleared; no partial events.

Optional Feature:
MOUSE_POS_ACCEL_EN: defined -> delta with |d| >= ACCEL_THRESH is doubled before add (per axis, sign kept), then clamped. Undefined -> deltas applied 1:1; ACCEL_THRESH unused.

Decomposition:
- mouse_pkg: PS2_DELTA_W=9, MAX_BTN=8, evt_t packed struct {logic [2:0] idx; logic press;}, clamp helper function.
- Sub-module mouse_evt_fifo: synchronous FIFO of evt_t, parameter DEPTH, push/pop/full/empty; tracker instantiates it once.

Test Plan:
- Reset, pkt dx=+10 dy=+5 INVERT_Y=1 from warp (100,100) -> (110,95) one cycle after strobe.
- At (5,5) pkt dx=-20 dy=-256 -> (0, 261); at (635,470) dx=+100 dy=-100 -> (639,479).
- btn_i 000->101 in one packet -> events {0,press},{2,press} in that order over 2 cycles; sticky=101; ack_i=001 -> sticky=100.
- EVT_DEPTH=2, three button changes without pop -> 2 events held, evt_ovf_o=1; ovf_clr_i -> 0.
- set_i and pkt_valid_i same cycle, set=(50,60), dx=+30 -> (50,60); buttons still updated.
- With MOUSE_POS_ACCEL_EN, ACCEL_THRESH=16: dx=+20 from x=100 -> 140; dx=+15 -> 115. Without macro dx=+20 -> 120.
